// File: rtl/sseg_pkg.sv
// sseg_pkg: shared constants for the seven-segment display controller.
//   SEG_OFF      all segments dark (active-low)
//   GLYPH_0..F   active-low a..g patterns for hex digits, index 0 = segment a
//   idx_w()      width of a digit index for a given digit count (min 1)
package sseg_pkg;

    localparam logic [0:6] SEG_OFF = 7'b1111111;

    localparam logic [0:6] GLYPH_0 = 7'b0000001;
    localparam logic [0:6] GLYPH_1 = 7'b1001111;
    localparam logic [0:6] GLYPH_2 = 7'b0010010;
    localparam logic [0:6] GLYPH_3 = 7'b0000110;
    localparam logic [0:6] GLYPH_4 = 7'b1001100;
    localparam logic [0:6] GLYPH_5 = 7'b0100100;
    localparam logic [0:6] GLYPH_6 = 7'b0100000;
    localparam logic [0:6] GLYPH_7 = 7'b0001111;
    localparam logic [0:6] GLYPH_8 = 7'b0000000;
    localparam logic [0:6] GLYPH_9 = 7'b0000100;
    localparam logic [0:6] GLYPH_A = 7'b0001000;
    localparam logic [0:6] GLYPH_B = 7'b1100000;
    localparam logic [0:6] GLYPH_C = 7'b0110001;
    localparam logic [0:6] GLYPH_D = 7'b1000010;
    localparam logic [0:6] GLYPH_E = 7'b0110000;
    localparam logic [0:6] GLYPH_F = 7'b0111000;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sseg_driver.sv
// sseg_driver: combinational hex-nibble to seven-segment decoder.
//   num    in   4       hex nibble
//   dp_en  in   1       1 = decimal point lit
//   sseg   out  [0:6]   segments a..g, active-low
//   dp     out  1       decimal point, active-low
module sseg_driver
    import sseg_pkg::*;
(
    input  logic [3:0] num,
    input  logic       dp_en,
    output logic [0:6] sseg,
    output logic       dp
);

    always_comb begin
        sseg = SEG_OFF;
        case (num)
            4'h0:    sseg = GLYPH_0;
            4'h1:    sseg = GLYPH_1;
            4'h2:    sseg = GLYPH_2;
            4'h3:    sseg = GLYPH_3;
            4'h4:    sseg = GLYPH_4;
            4'h5:    sseg = GLYPH_5;
            4'h6:    sseg = GLYPH_6;
            4'h7:    sseg = GLYPH_7;
            4'h8:    sseg = GLYPH_8;
            4'h9:    sseg = GLYPH_9;
            4'hA:    sseg = GLYPH_A;
            4'hB:    sseg = GLYPH_B;
            4'hC:    sseg = GLYPH_C;
            4'hD:    sseg = GLYPH_D;
            4'hE:    sseg = GLYPH_E;
            default: sseg = GLYPH_F;
        endcase
        dp = ~dp_en;
    end

endmodule

// File: rtl/sseg_mux_display.sv
// sseg_mux_display: time-multiplexed common-anode seven-segment controller.
// One digit is scanned per slot of 2^DIV_BITS clocks. Frame data is latched
// into shadow registers at the frame wrap so a frame never shows mixed data.
//   mclk        in   1             system clock
//   reset       in   1             synchronous, active-high
//   value       in   4*NUM_DIGITS  hex nibble per digit
//   dp_in       in   NUM_DIGITS    decimal point per digit
//   blank       in   NUM_DIGITS    force digit dark
//   blink       in   NUM_DIGITS    digit dark during blink phase
//   lz_en       in   1             suppress leading zeros
//   brightness  in   4             lit for (brightness+1)/16 of a slot
//   seg         out  [0:6]         segments a..g, active-low
//   dp          out  1             decimal point, active-low
//   an          out  NUM_DIGITS    anode enables, active-low, one-hot-low
//   frame_tick  out  1             pulse when the scan wraps to digit 0
module sseg_mux_display
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_BITS   = 18,
    parameter int BLINK_BITS = 25
) (
    input  logic                      mclk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank,
    input  logic [NUM_DIGITS-1:0]     blink,
    input  logic                      lz_en,
    input  logic [3:0]                brightness,
    output logic [0:6]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_tick
);

    localparam int                IDX_W    = idx_w(NUM_DIGITS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_BITS-1:0]     pres_q, pres_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [BLINK_BITS-1:0]   blink_cnt_q, blink_cnt_d;
    logic [4*NUM_DIGITS-1:0] value_sh_q, value_sh_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [NUM_DIGITS-1:0]   blank_sh_q, blank_sh_d;
    logic [NUM_DIGITS-1:0]   blink_sh_q, blink_sh_d;
    logic                    lz_sh_q, lz_sh_d;
    logic [0:6]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_tick_q, frame_tick_d;

    logic                    slot_end, wrap;
    logic [3:0]              cur_nib;
    logic                    cur_dp, cur_blank, cur_blink;
    logic                    upper_nonzero, lz_dark, dark, pwm_on, lit;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic [0:6]              dec_seg;
    logic                    dec_dp;

    sseg_driver u_driver (
        .num   (cur_nib),
        .dp_en (cur_dp),
        .sseg  (dec_seg),
        .dp    (dec_dp)
    );

    always_comb begin
        slot_end    = &pres_q;
        wrap        = slot_end && (idx_q == LAST_IDX);
        pres_d      = pres_q + DIV_BITS'(1);
        blink_cnt_d = blink_cnt_q + BLINK_BITS'(1);
        idx_d       = idx_q;
        if (slot_end) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end

        // The shadow reloads on the same edge that returns the scan to digit 0.
        value_sh_d   = wrap ? value : value_sh_q;
        dp_sh_d      = wrap ? dp_in : dp_sh_q;
        blank_sh_d   = wrap ? blank : blank_sh_q;
        blink_sh_d   = wrap ? blink : blink_sh_q;
        lz_sh_d      = wrap ? lz_en : lz_sh_q;
        frame_tick_d = wrap;

        // Select the current digit and find any non-zero nibble or dp at or
        // above it; without one the digit is a leading zero.
        cur_nib       = 4'h0;
        cur_dp        = 1'b0;
        cur_blank     = 1'b0;
        cur_blink     = 1'b0;
        an_sel        = '1;
        upper_nonzero = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = value_sh_q[4*i +: 4];
                cur_dp    = dp_sh_q[i];
                cur_blank = blank_sh_q[i];
                cur_blink = blink_sh_q[i];
                an_sel[i] = 1'b0;
            end
            if ((IDX_W'(i) >= idx_q) && ((value_sh_q[4*i +: 4] != 4'h0) || dp_sh_q[i])) begin
                upper_nonzero = 1'b1;
            end
        end

        lz_dark = lz_sh_q && (idx_q != '0) && !upper_nonzero;
        dark    = cur_blank || (cur_blink && blink_cnt_q[BLINK_BITS-1]) || lz_dark;
        pwm_on  = pres_q[DIV_BITS-1 -: 4] <= brightness;
        lit     = !dark && pwm_on;

        an_d  = lit ? an_sel  : '1;
        seg_d = lit ? dec_seg : SEG_OFF;
        dp_d  = lit ? dec_dp  : 1'b1;
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            pres_q       <= '0;
            idx_q        <= '0;
            blink_cnt_q  <= '0;
            value_sh_q   <= value;
            dp_sh_q      <= dp_in;
            blank_sh_q   <= blank;
            blink_sh_q   <= blink;
            lz_sh_q      <= lz_en;
            an_q         <= '1;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            pres_q       <= pres_d;
            idx_q        <= idx_d;
            blink_cnt_q  <= blink_cnt_d;
            value_sh_q   <= value_sh_d;
            dp_sh_q      <= dp_sh_d;
            blank_sh_q   <= blank_sh_d;
            blink_sh_q   <= blink_sh_d;
            lz_sh_q      <= lz_sh_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg_mux_display.sv
// tb_sseg_mux_display: drives a 4-digit and a 3-digit controller from shared
// stimulus and checks every output cycle against a reference model that
// derives the scan position from a cycle count since reset.
module tb_sseg_mux_display;

    localparam int W  = 17;   // {frame_tick, an[7:0], seg[0:6], dp}
    localparam int BB = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp_in, blank, blink;
    logic        lz_en;
    logic [3:0]  brightness;

    logic [0:6]  seg4, seg3;
    logic        dp4, dp3, ft4, ft3;
    logic [3:0]  an4;
    logic [2:0]  an3;

    sseg_mux_display #(.NUM_DIGITS(4), .DIV_BITS(6), .BLINK_BITS(BB)) dut4 (
        .mclk(clk), .reset(reset), .value(value), .dp_in(dp_in), .blank(blank),
        .blink(blink), .lz_en(lz_en), .brightness(brightness),
        .seg(seg4), .dp(dp4), .an(an4), .frame_tick(ft4)
    );

    sseg_mux_display #(.NUM_DIGITS(3), .DIV_BITS(4), .BLINK_BITS(BB)) dut3 (
        .mclk(clk), .reset(reset), .value(value[11:0]), .dp_in(dp_in[2:0]),
        .blank(blank[2:0]), .blink(blink[2:0]), .lz_en(lz_en), .brightness(brightness),
        .seg(seg3), .dp(dp3), .an(an3), .frame_tick(ft3)
    );

    // ---------------- reference model ----------------
    // Lit segments a..g (a = bit 6) of the standard hex glyphs.
    function automatic logic [6:0] glyph_on(input logic [3:0] n);
        case (n)
            4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
            4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
            4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
            4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
        endcase
    endfunction

    // Outputs for the cycle c clocks after reset (frame_tick bit left 0).
    function automatic logic [W-1:0] predict(input int n, input int d, input int c,
                                             input logic [15:0] val, input logic [3:0] dpm,
                                             input logic [3:0] bl, input logic [3:0] bk,
                                             input logic lz, input logic [3:0] br);
        int         pres, idx, top;
        logic       phase, dark, zero_above;
        logic [3:0] nib;
        logic [7:0] an_e;
        pres  = c % (1 << d);
        idx   = (c >> d) % n;
        top   = pres >> (d - 4);
        phase = ((c >> (BB - 1)) % 2) == 1;
        nib   = val[4*idx +: 4];
        zero_above = 1'b1;
        for (int j = idx; j < n; j++) begin
            if (val[4*j +: 4] != 4'h0 || dpm[j]) zero_above = 1'b0;
        end
        dark = bl[idx] || (bk[idx] && phase) || (lz && idx > 0 && zero_above);
        if (dark || top > int'(br)) return {1'b0, 8'hFF, 7'h7F, 1'b1};
        an_e = 8'hFF;
        an_e[idx] = 1'b0;
        return {1'b0, an_e, ~glyph_on(nib), ~dpm[idx]};
    endfunction

    logic [W-1:0] exp_q4[$];
    logic [W-1:0] exp_q3[$];

    int          m_c    [2];
    bit          m_live [2] = '{0, 0};
    logic [15:0] sh_val [2];
    logic [3:0]  sh_dp  [2], sh_bl [2], sh_bk [2];
    logic        sh_lz  [2];

    always @(posedge clk) begin : model
        logic [W-1:0] e;
        int n, d;
        for (int m = 0; m < 2; m++) begin
            n = (m == 0) ? 4 : 3;
            d = (m == 0) ? 6 : 4;
            e = '0;
            if (reset) begin
                m_c[m] = 0; m_live[m] = 1;
                sh_val[m] = value; sh_dp[m] = dp_in; sh_bl[m] = blank;
                sh_bk[m] = blink; sh_lz[m] = lz_en;
                e = {1'b0, 8'hFF, 7'h7F, 1'b1};
            end else if (m_live[m]) begin
                e = predict(n, d, m_c[m], sh_val[m], sh_dp[m], sh_bl[m], sh_bk[m],
                            sh_lz[m], brightness);
                e[16] = ((m_c[m] + 1) % (n * (1 << d))) == 0;
                if (e[16]) begin
                    sh_val[m] = value; sh_dp[m] = dp_in; sh_bl[m] = blank;
                    sh_bk[m] = blink; sh_lz[m] = lz_en;
                end
                m_c[m] = m_c[m] + 1;
            end
            if (m_live[m]) begin
                if (m == 0) exp_q4.push_back(e);
                else        exp_q3.push_back(e);
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_ft4 = -1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s @%0t: got ft=%b an=%b seg=%b dp=%b, want ft=%b an=%b seg=%b dp=%b",
                     name, $time, act[16], act[15:8], act[7:1], act[0],
                     want[16], want[15:8], want[7:1], want[0]);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [W-1:0] e;
        cyc++;
        if (exp_q4.size() > 0) begin
            e = exp_q4.pop_front();
            check("dut4_out", {ft4, 4'hF, an4, seg4, dp4}, e);
        end
        if (exp_q3.size() > 0) begin
            e = exp_q3.pop_front();
            check("dut3_out", {ft3, 5'h1F, an3, seg3, dp3}, e);
        end
        if (reset) begin
            last_ft4 = -1;
        end else if (ft4 === 1'b1) begin
            if (last_ft4 >= 0) begin
                total++;
                if (cyc - last_ft4 != 256) begin
                    bad++;
                    $display("FAIL ft_period: got %0d cycles, want 256", cyc - last_ft4);
                end
            end
            last_ft4 = cyc;
        end
    end

    // ---------------- driver ----------------
    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_inputs(input logic [15:0] v, input logic [3:0] dpm, input logic [3:0] bl,
                              input logic [3:0] bk, input logic lz, input logic [3:0] br);
        value = v; dp_in = dpm; blank = bl; blink = bk; lz_en = lz; brightness = br;
    endtask

    initial begin
        reset = 1'b1;
        set_inputs(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 4'd15);
        run(5);
        reset = 1'b0;
        run(520);

        // leading-zero suppression, then a dp that stops it
        set_inputs(16'h0050, 4'h0, 4'h0, 4'h0, 1'b1, 4'd15);
        run(520);
        dp_in = 4'b0100;
        run(520);

        // data change mid-frame
        set_inputs(16'h1111, 4'h0, 4'h0, 4'h0, 1'b0, 4'd15);
        run(330);
        value = 16'h2222;
        run(520);

        // PWM brightness
        brightness = 4'd3;
        run(520);
        brightness = 4'd15;

        // blink and blank
        set_inputs(16'h8421, 4'h0, 4'b1000, 4'b0001, 1'b0, 4'd15);
        run(2100);

        // randomized inputs with occasional mid-slot resets
        for (int k = 0; k < 30; k++) begin
            set_inputs(16'($urandom), 4'($urandom & $urandom), 4'($urandom & $urandom & $urandom),
                       4'($urandom & $urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            run($urandom_range(30, 400));
            if ($urandom_range(0, 3) == 0) begin
                reset = 1'b1;
                run($urandom_range(1, 3));
                reset = 1'b0;
            end
        end

        run(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
